// File: rtl/byte_to_word64_packer.sv
// byte_to_word64_packer: gathers a serial byte stream into 64-bit words and
// presents them on a valid/ready output backed by a one-word buffer, so that
// byte accumulation can continue while the consumer stalls.
// Optional feature macro: PACK_FLUSH_EN adds a 'flush' input that closes a
// partial word early, filling the missing byte lanes with PAD_BYTE.
module byte_to_word64_packer #(
   parameter bit         MSB_FIRST = 1'b0,
   parameter logic [7:0] PAD_BYTE  = 8'h00
) (
   input  logic        clk,
   input  logic        rst,
`ifdef PACK_FLUSH_EN
   input  logic        flush,
`endif
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [63:0] out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [2:0]  byte_cnt
);

   typedef enum logic {
      BUF_EMPTY = 1'b0,
      BUF_FULL  = 1'b1
   } buf_state_t;

   buf_state_t  buf_state;
   buf_state_t  buf_state_nxt;
   logic [63:0] acc;
   logic [63:0] merged;
   logic [3:0]  fill_cnt;
   logic        flush_req;
   logic        byte_fire;
   logic        word_fire;
   logic        flush_fire;
   logic        word_done;

`ifdef PACK_FLUSH_EN
   assign flush_req = flush;
`else
   assign flush_req = 1'b0;
`endif

   // Byte lane (0 = bits [7:0]) that the k-th byte of a word occupies.
   function automatic logic [2:0] lane_of(input logic [2:0] k);
      return MSB_FIRST ? 3'(3'd7 - k) : k;
   endfunction

   // Replace every byte position at or beyond 'n' with the pad value.
   function automatic logic [63:0] pad_word(input logic [63:0] w, input logic [3:0] n);
      logic [63:0] r;
      r = w;
      for (int k = 0; k < 8; k++) begin
         if (k >= int'(n)) begin
            r[{lane_of(3'(k)), 3'b000} +: 8] = PAD_BYTE;
         end
      end
      return r;
   endfunction

   assign out_valid = (buf_state == BUF_FULL);

   // Handshake qualifiers; in_ready uses only registered state plus the
   // upstream flush request, never out_ready, so no timing path runs
   // from the consumer back to the producer.
   always_comb begin
      in_ready   = !(out_valid && ((byte_cnt == 3'd7) ||
                                   (flush_req && (byte_cnt != 3'd0))));
      byte_fire  = in_valid && in_ready;
      word_fire  = out_valid && out_ready;
      flush_fire = flush_req && (byte_cnt != 3'd0) && !out_valid;
      word_done  = (byte_fire && (byte_cnt == 3'd7)) || flush_fire;
      fill_cnt   = {1'b0, byte_cnt} + {3'b000, byte_fire};
   end

   // Word candidate: accumulator plus this cycle's byte, padded when short.
   always_comb begin
      merged = acc;
      if (byte_fire) begin
         merged[{lane_of(byte_cnt), 3'b000} +: 8] = in_data;
      end
      merged = pad_word(merged, fill_cnt);
   end

   // Output buffer next state; a completion always (re)loads the buffer,
   // including the case where the old word leaves on the same edge.
   always_comb begin
      buf_state_nxt = buf_state;
      case (buf_state)
         BUF_EMPTY: if (word_done) buf_state_nxt = BUF_FULL;
         BUF_FULL: begin
            if (word_done) begin
               buf_state_nxt = BUF_FULL;
            end else if (word_fire) begin
               buf_state_nxt = BUF_EMPTY;
            end
         end
         default: buf_state_nxt = BUF_EMPTY;
      endcase
   end

   // Output buffer state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buf_state <= BUF_EMPTY;
      end else begin
         buf_state <= buf_state_nxt;
      end
   end

   // Output word register: changes only when a new word is loaded.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_data <= 64'h0;
      end else if (word_done) begin
         out_data <= merged;
      end
   end

   // Accumulator and byte counter; both clear when a word leaves them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc      <= 64'h0;
         byte_cnt <= 3'd0;
      end else if (word_done) begin
         acc      <= 64'h0;
         byte_cnt <= 3'd0;
      end else if (byte_fire) begin
         acc[{lane_of(byte_cnt), 3'b000} +: 8] <= in_data;
         byte_cnt <= byte_cnt + 3'd1;
      end
   end

endmodule

// File: tb/tb_byte_to_word64_packer.sv
// Testbench for byte_to_word64_packer: two instances (LSB-first and
// MSB-first) share one stimulus stream and are compared against a
// queue-based reference model of the byte stream and pending words.
module tb_byte_to_word64_packer;

`ifdef PACK_FLUSH_EN
   localparam logic [7:0] PAD = 8'hFF;
`else
   localparam logic [7:0] PAD = 8'h00;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  in_data = 8'h00;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic        flush = 1'b0;
   logic        in_ready0, in_ready1;
   logic        out_valid0, out_valid1;
   logic [63:0] out_data0, out_data1;
   logic [2:0]  byte_cnt0, byte_cnt1;

   int n_cmp = 0;
   int n_err = 0;

   // reference model: bytes of the word in progress, and completed words
   logic [7:0]  part[$];
   logic [63:0] wq0[$];
   logic [63:0] wq1[$];

   always #5 clk = ~clk;

   byte_to_word64_packer #(.MSB_FIRST(1'b0), .PAD_BYTE(PAD)) dut0 (
      .clk(clk), .rst(rst),
`ifdef PACK_FLUSH_EN
      .flush(flush),
`endif
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready0),
      .out_data(out_data0), .out_valid(out_valid0), .out_ready(out_ready),
      .byte_cnt(byte_cnt0)
   );

   byte_to_word64_packer #(.MSB_FIRST(1'b1), .PAD_BYTE(PAD)) dut1 (
      .clk(clk), .rst(rst),
`ifdef PACK_FLUSH_EN
      .flush(flush),
`endif
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready1),
      .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready),
      .byte_cnt(byte_cnt1)
   );

   function automatic logic [63:0] build(input bit msb);
      logic [63:0] w;
      w = {8{PAD}};
      for (int k = 0; k < part.size(); k++) begin
         if (msb) w[63-8*k -: 8] = part[k];
         else     w[8*k +: 8]    = part[k];
      end
      return w;
   endfunction

   function automatic bit m_valid();
      return wq0.size() != 0;
   endfunction

   function automatic bit m_in_ready();
      return !(m_valid() && (part.size() == 7 || (flush && part.size() != 0)));
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      bit ir;
      bit v;
      ir = m_in_ready();
      v  = m_valid();
      check("in_ready0",  64'(in_ready0),  64'(ir));
      check("in_ready1",  64'(in_ready1),  64'(ir));
      check("out_valid0", 64'(out_valid0), 64'(v));
      check("out_valid1", 64'(out_valid1), 64'(v));
      check("byte_cnt0",  64'(byte_cnt0),  64'(part.size()));
      check("byte_cnt1",  64'(byte_cnt1),  64'(part.size()));
      if (v) begin
         check("out_data0", out_data0, wq0[0]);
         check("out_data1", out_data1, wq1[0]);
      end
   endtask

   // One clock with the currently driven inputs; model follows the edge.
   task automatic tick(output bit accepted);
      bit bf, wf, ff;
      bf = in_valid && m_in_ready();
      wf = m_valid() && out_ready;
      ff = flush && (part.size() != 0) && !m_valid();
      @(posedge clk);
      if (wf) begin
         void'(wq0.pop_front());
         void'(wq1.pop_front());
      end
      if (bf) part.push_back(in_data);
      if (part.size() == 8 || ff) begin
         wq0.push_back(build(1'b0));
         wq1.push_back(build(1'b1));
         part.delete();
      end
      @(negedge clk);
      check_all();
      accepted = bf;
   endtask

   task automatic idle(input bit ordy);
      bit a;
      in_valid  = 1'b0;
      out_ready = ordy;
      tick(a);
   endtask

   task automatic send_byte(input logic [7:0] d, input bit ordy);
      bit a;
      bit got;
      got       = 1'b0;
      in_valid  = 1'b1;
      in_data   = d;
      out_ready = ordy;
      for (int i = 0; i < 20 && !got; i++) begin
         tick(a);
         got = a;
      end
      n_cmp++;
      assert (got) else begin
         n_err++;
         $error("FAIL byte_accept_timeout: observed not accepted expected accepted (byte %h)", d);
      end
      in_valid = 1'b0;
   endtask

   // Asynchronous reset pulse placed mid-cycle, checked before any edge.
   task automatic do_reset();
      #2 rst = 1'b1;
      #1;
      check("async_rst_valid0", 64'(out_valid0), 64'd0);
      check("async_rst_cnt0",   64'(byte_cnt0),  64'd0);
      check("async_rst_cnt1",   64'(byte_cnt1),  64'd0);
      check("async_rst_data0",  out_data0,       64'h0);
      part.delete();
      wq0.delete();
      wq1.delete();
      in_valid = 1'b0;
      flush    = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_all();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed simulation still running expected finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int words;
      bit a;

      // reset values
      @(negedge clk);
      check("rst_valid0", 64'(out_valid0), 64'd0);
      check("rst_data0",  out_data0,       64'h0);
      check("rst_data1",  out_data1,       64'h0);
      check("rst_cnt0",   64'(byte_cnt0),  64'd0);
      rst = 1'b0;
      #1;
      check("rst_in_ready0", 64'(in_ready0), 64'd1);

      // bytes 01..08, consumer ready
      for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b1);
      check("lsb_word", out_data0, 64'h0807060504030201);
      check("msb_word", out_data1, 64'h0102030405060708);
      idle(1'b1);
      idle(1'b1);

      // consumer stalled across two words
      do_reset();
      for (int i = 0; i < 15; i++) send_byte(8'(i), 1'b0);
      check("stall_word0",  out_data0,       64'h0706050403020100);
      check("stall_ready0", 64'(in_ready0),  64'd0);
      check("stall_cnt0",   64'(byte_cnt0),  64'd7);
      in_valid  = 1'b1;
      in_data   = 8'h0F;
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) tick(a);
      send_byte(8'h0F, 1'b1);
      check("stall_word1", out_data0, 64'h0F0E0D0C0B0A0908);
      idle(1'b1);
      idle(1'b1);

      // back-to-back words with a ready consumer
      do_reset();
      words = 0;
      for (int i = 0; i < 64; i++) begin
         send_byte(8'($urandom_range(0, 255)), 1'b1);
         if (out_valid0) words++;
      end
      idle(1'b1);
      check("b2b_words", 64'(words), 64'd8);

      // reset mid-word discards the partial bytes
      for (int i = 0; i < 5; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
      do_reset();
      for (int i = 0; i < 8; i++) send_byte(8'(8'hA0 + i), 1'b0);
      check("post_rst_word", out_data0, 64'hA7A6A5A4A3A2A1A0);
      idle(1'b1);

      // randomized traffic
      do_reset();
      for (int i = 0; i < 800; i++) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         in_data   = 8'($urandom_range(0, 255));
         out_ready = ($urandom_range(0, 1) == 1);
`ifdef PACK_FLUSH_EN
         flush     = ($urandom_range(0, 19) == 0);
`endif
         tick(a);
      end
      in_valid = 1'b0;
      flush    = 1'b0;

`ifdef PACK_FLUSH_EN
      // flush of a three-byte partial word
      do_reset();
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      send_byte(8'h33, 1'b0);
      flush = 1'b1;
      idle(1'b0);
      flush = 1'b0;
      check("flush_word0", out_data0, 64'hFFFFFFFFFF332211);
      check("flush_word1", out_data1, 64'h112233FFFFFFFFFF);
      check("flush_cnt0",  64'(byte_cnt0), 64'd0);
      idle(1'b1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
